// File: rtl/gsqrt_job_ctrl_pkg.sv
// Shared types and constants for the stochastic square-root job controller.
// Holds the FSM state encoding, LFSR tap masks and default seeds.
package gsqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [4:0] TAP_A = 5'b10100;
    localparam logic [4:0] TAP_B = 5'b10010;

    localparam logic [4:0] SEED_A_DEF = 5'b00001;
    localparam logic [4:0] SEED_B_DEF = 5'b10101;

    function automatic logic lfsr_fb(
        input logic [4:0] q,
        input logic [4:0] taps
    );
        return ^(q & taps);
    endfunction

endpackage

// File: rtl/gsqrt_job_ctrl_if.sv
// Request/response valid-ready bundle between the binary requester
// and the square-root job controller.
interface gsqrt_job_ctrl_if #(
    parameter int WIDTH   = 5,
    parameter int WIN_LOG = 8
);
    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIN_LOG:0]   rsp_data;

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/gsqrt_job_ctrl_lfsr5.sv
// 5-bit Fibonacci LFSR: shifts left, feedback enters at the LSB.
// A load reseeds, a step advances by one state.
module lfsr5
    import gsqrt_pkg::*;
#(
    parameter logic [4:0] TAPS = TAP_A,
    parameter logic [4:0] SEED = SEED_A_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [4:0] q
);
    logic [4:0] r_q;
    logic       w_fb;

    assign w_fb = lfsr_fb(r_q, TAPS);
    assign q    = r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (step) begin
            r_q <= {r_q[3:0], w_fb};
        end
    end
endmodule

// File: rtl/gsqrt_job_ctrl.sv
// Job sequencer for a 5-bit counter-based stochastic square-root core:
// drives the core's streams, warms it up, then counts its output ones.
module gsqrt_job_ctrl
    import gsqrt_pkg::*;
#(
    parameter int         WIDTH    = 5,
    parameter int         WARM_CYC = 16,
    parameter int         WIN_LOG  = 8,
    parameter logic [4:0] SEED_A   = SEED_A_DEF,
    parameter logic [4:0] SEED_B   = SEED_B_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    gsqrt_job_ctrl_if.slave  bus,
    output logic             sqrt_in,
    output logic [WIDTH-1:0] sqrt_rand,
    input  logic             sqrt_out,
    output logic             busy
);
    localparam logic [7:0] WARM_LAST = 8'(WARM_CYC - 1);
    localparam logic [WIN_LOG-1:0] WIN_LAST = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_x;
    logic [7:0]         r_warm;
    logic [WIN_LOG-1:0] r_win;
    logic [WIN_LOG:0]   r_acc;
    logic [WIN_LOG:0]   r_rsp;
    logic [WIN_LOG:0]   w_acc_nxt;
    logic               w_accept;
    logic               w_load;
    logic               w_step;
    logic               w_active;
    logic [4:0]         w_lfsr_a;
    logic [4:0]         w_lfsr_b;

    lfsr5 #(.TAPS(TAP_A), .SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .q     (w_lfsr_a)
    );

    lfsr5 #(.TAPS(TAP_B), .SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .q     (w_lfsr_b)
    );

    assign w_accept  = bus.req_valid && (r_state == S_IDLE);
    assign w_acc_nxt = r_acc + {{WIN_LOG{1'b0}}, sqrt_out};
    assign w_active  = (r_state == S_WARM) || (r_state == S_RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WARM;
                    w_load      = 1'b1;
                end
            end
            S_WARM: begin
                w_step = 1'b1;
                if (r_warm == WARM_LAST)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_win == WIN_LAST)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.rsp_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_warm <= '0;
            r_win  <= '0;
            r_acc  <= '0;
            r_rsp  <= '0;
        end else begin
            if (w_accept) begin
                r_x    <= bus.req_data;
                r_warm <= '0;
                r_win  <= '0;
                r_acc  <= '0;
            end
            if (r_state == S_WARM)
                r_warm <= r_warm + 8'd1;
            if (r_state == S_RUN) begin
                r_acc <= w_acc_nxt;
                r_win <= r_win + 1'b1;
                // result is captured with the final sample folded in
                if (r_win == WIN_LAST)
                    r_rsp <= w_acc_nxt;
            end
        end
    end

    assign sqrt_in   = w_active && (w_lfsr_a <= r_x);
    assign sqrt_rand = w_active ? w_lfsr_b : '0;
    assign busy      = w_active;

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_DONE);
    assign bus.rsp_data  = r_rsp;
endmodule

// File: tb/tb_gsqrt_job_ctrl.sv
// Scoreboard bench for gsqrt_job_ctrl with a stubbed core output.
// Responses are checked by a monitor against a queue of expectations.
module tb_gsqrt_job_ctrl;
    localparam int WL   = 8;
    localparam int WARM = 16;
    localparam int LAT  = WARM + (1 << WL);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sqrt_in;
    logic [4:0] sqrt_rand;
    logic       sqrt_out;
    logic       busy;

    always #5 clk = ~clk;

    gsqrt_job_ctrl_if #(.WIDTH(5), .WIN_LOG(WL)) bus ();

    gsqrt_job_ctrl #(
        .WIDTH    (5),
        .WARM_CYC (WARM),
        .WIN_LOG  (WL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sqrt_in   (sqrt_in),
        .sqrt_rand (sqrt_rand),
        .sqrt_out  (sqrt_out),
        .busy      (busy)
    );

    typedef struct {
        int data;
        int acc_edge;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   rise_cyc = -1;
    int   hs_edge = -1;
    int   unexp = 0;
    int   bad_ready = 0;
    int   bad_in = 0;
    int   in_mode = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.rsp_valid && !prev_v)
                rise_cyc = cyc;
            if (busy && bus.req_ready)
                bad_ready++;
            if (busy && in_mode == 1 && sqrt_in !== 1'b0)
                bad_in++;
            if (busy && in_mode == 2 && sqrt_in !== 1'b1)
                bad_in++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                hs_edge = cyc + 1;
                if (sbq.size() == 0) begin
                    unexp++;
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_data", int'(bus.rsp_data), e.data);
                    chk("rsp_latency", rise_cyc - e.acc_edge, LAT);
                end
            end
        end
        prev_v = bus.rsp_valid;
    end

    task automatic send(input logic [4:0] x, output int edge_n);
        bus.req_data  = x;
        bus.req_valid = 1'b1;
        edge_n = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                edge_n = cyc + 1;
                break;
            end
        end
        if (edge_n < 0)
            chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic push(input int d, input int e);
        exp_t x;
        x.data = d;
        x.acc_edge = e;
        sbq.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    int la[4] = '{1, 2, 4, 9};
    int lb[4] = '{21, 11, 23, 14};

    initial begin
        int e;
        int e2;
        int unstable;
        int seen_ready;
        int got_v;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        sqrt_out      = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sqrt_in", int'(sqrt_in), 0);
        chk("rst_sqrt_rand", int'(sqrt_rand), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        sqrt_out = 1'b1;
        send(5'd17, e);
        push(256, e);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lfsr_a", int'(dut.u_lfsr_a.r_q), la[k]);
            chk("sqrt_rand", int'(sqrt_rand), lb[k]);
            chk("sqrt_in_x17", int'(sqrt_in), 1);
            chk("busy_warm", int'(busy), 1);
        end
        drain();

        sqrt_out = 1'b0;
        in_mode = 1;
        bad_in = 0;
        send(5'd0, e);
        push(0, e);
        drain();
        in_mode = 0;
        chk("sqrt_in_x0", bad_in, 0);

        in_mode = 2;
        bad_in = 0;
        send(5'd31, e);
        push(0, e);
        drain();
        in_mode = 0;
        chk("sqrt_in_x31", bad_in, 0);

        sqrt_out = 1'b1;
        bus.rsp_ready = 1'b0;
        send(5'd5, e);
        push(256, e);
        got_v = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got_v = 1;
                break;
            end
        end
        chk("bp_valid_seen", got_v, 1);
        bus.req_data  = 5'd9;
        bus.req_valid = 1'b1;
        unstable = 0;
        seen_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data != 9'd256)
                unstable++;
            if (bus.req_ready)
                seen_ready++;
        end
        chk("bp_stable", unstable, 0);
        chk("bp_no_accept", seen_ready, 0);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        send(5'd9, e2);
        chk("accept_after_hs", e2 - hs_edge, 1);
        push(256, e2);
        drain();

        send(5'd17, e);
        repeat (WARM + 100) @(posedge clk);
        #1;
        chk("busy_before_abort", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", int'(bus.rsp_valid), 0);
        chk("abort_sqrt_in", int'(sqrt_in), 0);
        chk("abort_sqrt_rand", int'(sqrt_rand), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", int'(bus.req_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        send(5'd17, e);
        push(256, e);
        drain();

        repeat (5) @(posedge clk);
        chk("ready_while_busy", bad_ready, 0);
        chk("unexpected_rsp", unexp, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
endmodule
